// File: rtl/rx_frame_if.sv
// Byte-stream input and published-frame output bundle for rx_frame.
// The parser sits on the slave side; the UART receiver and frame consumer sit on the master side.
interface rx_frame_if #(
    parameter int MAX_LEN = 32
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 frame_valid;
    logic [7:0]           frame_type;
    logic [7:0]           frame_len;
    logic [8*MAX_LEN-1:0] payload_bus;
    logic                 chk_err;
    logic                 len_err;
    logic                 timeout_err;
    logic                 busy;

    modport master (
        output rx_data, rx_valid,
        input  frame_valid, frame_type, frame_len, payload_bus,
        input  chk_err, len_err, timeout_err, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output frame_valid, frame_type, frame_len, payload_bus,
        output chk_err, len_err, timeout_err, busy
    );
endinterface

// File: rtl/rx_frame.sv
// Parses [AA][TYPE][LEN][PAYLOAD][CHK] frames; results and error pulses are registered one cycle after the deciding byte.
// No backpressure: accepts one byte per cycle. Define RX_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle cycles.
module rx_frame #(
    parameter int MAX_LEN        = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    rx_frame_if.slave  bus
);
    typedef enum logic [2:0] {R_SOF, R_TYPE, R_LEN, R_PAY, R_CHK} state_t;

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0] SOF_BYTE  = 8'hAA;

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("rx_frame: MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rx_frame: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                   state_q;
    logic [7:0]               type_q;
    logic [7:0]               len_q;
    logic [7:0]               sum_q;
    logic [7:0]               idx_q;
    logic [MAX_LEN-1:0][7:0]  buf_q;
    logic                     frame_valid_q;
    logic                     chk_err_q;
    logic                     len_err_q;
    logic [7:0]               frame_type_q;
    logic [7:0]               frame_len_q;
    logic [MAX_LEN-1:0][7:0]  payload_q;

    logic [7:0] sum_d;
    logic [7:0] idx_d;

    assign sum_d = sum_q + bus.rx_data;
    assign idx_d = idx_q + 8'd1;

`ifdef RX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= R_SOF;
            type_q        <= '0;
            len_q         <= '0;
            sum_q         <= '0;
            idx_q         <= '0;
            buf_q         <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            frame_type_q  <= '0;
            frame_len_q   <= '0;
            payload_q     <= '0;
`ifdef RX_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            if (bus.rx_valid) begin
                unique case (state_q)
                    R_SOF: begin
                        if (bus.rx_data == SOF_BYTE) begin
                            sum_q   <= '0;
                            idx_q   <= '0;
                            state_q <= R_TYPE;
                        end
                    end
                    R_TYPE: begin
                        type_q  <= bus.rx_data;
                        sum_q   <= bus.rx_data;
                        state_q <= R_LEN;
                    end
                    R_LEN: begin
                        if (bus.rx_data > MAX_LEN_B) begin
                            len_err_q <= 1'b1;
                            state_q   <= R_SOF;
                        end else begin
                            len_q   <= bus.rx_data;
                            sum_q   <= sum_d;
                            state_q <= (bus.rx_data == 8'd0) ? R_CHK : R_PAY;
                        end
                    end
                    R_PAY: begin
                        // 0xAA is plain data here: no resync once a frame has started
                        buf_q[idx_q[IW-1:0]] <= bus.rx_data;
                        sum_q                <= sum_d;
                        idx_q                <= idx_d;
                        if (idx_d == len_q) begin
                            state_q <= R_CHK;
                        end
                    end
                    R_CHK: begin
                        if (bus.rx_data == sum_q) begin
                            frame_valid_q <= 1'b1;
                            frame_type_q  <= type_q;
                            frame_len_q   <= len_q;
                            payload_q     <= buf_q;
                        end else begin
                            chk_err_q <= 1'b1;
                        end
                        state_q <= R_SOF;
                    end
                    default: state_q <= R_SOF;
                endcase
            end
`ifdef RX_TIMEOUT_EN
            timeout_err_q <= 1'b0;
            if (bus.rx_valid) begin
                cnt_q <= '0;
            end else if (state_q != R_SOF) begin
                if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_q         <= '0;
                    timeout_err_q <= 1'b1;
                    state_q       <= R_SOF;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
`endif
        end
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_type  = frame_type_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.payload_bus = payload_q;
    assign bus.chk_err     = chk_err_q;
    assign bus.len_err     = len_err_q;
    assign bus.busy        = (state_q != R_SOF);
`ifdef RX_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_rx_frame.sv
// Randomised and directed bench for rx_frame; expected frames come from an array-scanning frame model.
module tb_rx_frame;
    localparam int MAX_LEN = 32;
`ifdef RX_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 100000;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]           t;
        logic [7:0]           l;
        logic [8*MAX_LEN-1:0] p;
    } frm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    frm_t got[$];
    frm_t exp_q[$];
    int   n_chk = 0, n_len = 0, n_to = 0, n_viol = 0;
    int   fv_cyc = -1, last_smp = 0;
    int   exp_chk = 0, exp_len = 0;
    logic [7:0] mbuf [MAX_LEN];
    logic [3:0] prev_p = '0;

    rx_frame_if #(.MAX_LEN(MAX_LEN)) bus ();

    rx_frame #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: captures published frames and pulse counts away from the active edge
    always @(negedge clk) begin
        logic [3:0] p;
        frm_t       f;
        p = {bus.frame_valid, bus.chk_err, bus.len_err, bus.timeout_err};
        if (rst) begin
            prev_p = '0;
        end else begin
            if (bus.frame_valid) begin
                f.t = bus.frame_type;
                f.l = bus.frame_len;
                f.p = bus.payload_bus;
                got.push_back(f);
                fv_cyc = cyc;
            end
            if (bus.chk_err)     n_chk++;
            if (bus.len_err)     n_len++;
            if (bus.timeout_err) n_to++;
            if ($countones(p) > 1)  n_viol++;
            if ((p & prev_p) != 0)  n_viol++;
            prev_p = p;
        end
    end

    // Frame model: scans the whole byte array for SOF and slices fields out by offset
    task automatic model_stream(input bq_t s);
        int         i;
        int         l;
        logic [7:0] t;
        logic [7:0] sum;
        frm_t       f;
        i = 0;
        exp_q.delete();
        exp_chk = 0;
        exp_len = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hAA) begin
                i++;
                continue;
            end
            if (i + 2 >= s.size()) break;
            t = s[i+1];
            l = int'(s[i+2]);
            if (l > MAX_LEN) begin
                exp_len++;
                i += 3;
                continue;
            end
            if (i + 3 + l >= s.size()) break;
            sum = t + 8'(l);
            for (int k = 0; k < l; k++) begin
                mbuf[k] = s[i+3+k];
                sum     = sum + s[i+3+k];
            end
            if (s[i+3+l] == sum) begin
                f.t = t;
                f.l = 8'(l);
                for (int k = 0; k < MAX_LEN; k++) f.p[8*k +: 8] = mbuf[k];
                exp_q.push_back(f);
            end else begin
                exp_chk++;
            end
            i += 4 + l;
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.rx_valid = v;
        bus.rx_data  = d;
    endtask

    task automatic play(input bq_t s, input int maxgap);
        foreach (s[i]) begin
            repeat ($urandom_range(maxgap, 0)) drive(1'b0, 8'($urandom));
            drive(1'b1, s[i]);
            last_smp = cyc + 1;
        end
        repeat (4) drive(1'b0, 8'h00);
        model_stream(s);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.frame_valid, bus.chk_err, bus.len_err, bus.timeout_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=0000", {bus.frame_valid, bus.chk_err, bus.len_err, bus.timeout_err});
        end
        checks++;
        if ({bus.frame_type, bus.frame_len} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_type_len got=%h exp=0000", {bus.frame_type, bus.frame_len});
        end
        checks++;
        if (bus.payload_bus !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload_busy got=%h busy=%b exp=0/0", bus.payload_bus, bus.busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        bq_t s;
        int  b = got.size(), c0 = n_chk, l0 = n_len;
        s = {8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        play(s, 0);
        checks++;
        if (got.size() - b != 1 || n_chk != c0 || n_len != l0) begin
            errors++;
            $display("FAIL good_counts frames=%0d chk=%0d len=%0d exp=1/0/0", got.size() - b, n_chk - c0, n_len - l0);
        end else begin
            checks++;
            if (got[b].t !== 8'h01 || got[b].l !== 8'h02 || got[b].p[15:0] !== 16'h2010) begin
                errors++;
                $display("FAIL good_fields got t=%h l=%h p=%h exp 01 02 2010", got[b].t, got[b].l, got[b].p[15:0]);
            end
            checks++;
            if (fv_cyc != last_smp) begin
                errors++;
                $display("FAIL good_latency got cycle=%0d exp=%0d", fv_cyc, last_smp);
            end
        end
    endtask

    task automatic test_bad_chk;
        bq_t s;
        int  b = got.size(), c0 = n_chk;
        s = {8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        play(s, 0);
        checks++;
        if (got.size() != b || n_chk - c0 != 1) begin
            errors++;
            $display("FAIL badchk_counts frames=%0d chk=%0d exp=0/1", got.size() - b, n_chk - c0);
        end
        checks++;
        if (bus.frame_type !== 8'h01 || bus.frame_len !== 8'h02 || bus.payload_bus[15:0] !== 16'h2010) begin
            errors++;
            $display("FAIL badchk_hold got %h %h %h exp 01 02 2010", bus.frame_type, bus.frame_len, bus.payload_bus[15:0]);
        end
    endtask

    task automatic test_gaps;
        bq_t s;
        int  b = got.size(), c0 = n_chk, l0 = n_len;
        s = {8'h00, 8'hFF, 8'hAA, 8'h07, 8'h01, 8'h55, 8'h5D};
        play(s, 5);
        checks++;
        if (got.size() - b != 1 || n_chk != c0 || n_len != l0) begin
            errors++;
            $display("FAIL gaps_counts frames=%0d chk=%0d len=%0d exp=1/0/0", got.size() - b, n_chk - c0, n_len - l0);
        end else begin
            checks++;
            if (got[b].t !== 8'h07 || got[b].l !== 8'h01 || got[b].p[7:0] !== 8'h55) begin
                errors++;
                $display("FAIL gaps_fields got %h %h %h exp 07 01 55", got[b].t, got[b].l, got[b].p[7:0]);
            end
        end
    endtask

    task automatic test_zero_len;
        bq_t s;
        int  b = got.size(), l0 = n_len;
        s = {8'hAA, 8'h05, 8'h00, 8'h05};
        play(s, 1);
        checks++;
        if (got.size() - b != 1) begin
            errors++;
            $display("FAIL zlen_count frames=%0d exp=1", got.size() - b);
        end else begin
            checks++;
            if (got[b].t !== 8'h05 || got[b].l !== 8'h00 || got[b].p !== exp_q[0].p) begin
                errors++;
                $display("FAIL zlen_fields got %h %h p=%h exp 05 00 p=%h", got[b].t, got[b].l, got[b].p, exp_q[0].p);
            end
        end
        b = got.size();
        s = {8'hAA, 8'h01, 8'h21, 8'hAA, 8'h01, 8'h00, 8'h01};
        play(s, 1);
        checks++;
        if (n_len - l0 != 1 || got.size() - b != 1) begin
            errors++;
            $display("FAIL lenerr_counts len=%0d frames=%0d exp=1/1", n_len - l0, got.size() - b);
        end else begin
            checks++;
            if (got[b].t !== 8'h01 || got[b].l !== 8'h00) begin
                errors++;
                $display("FAIL lenerr_next got %h %h exp 01 00", got[b].t, got[b].l);
            end
        end
    endtask

    task automatic test_aa_payload;
        bq_t s;
        int  b = got.size();
        s = {8'hAA, 8'h02, 8'h01, 8'hAA, 8'hAD};
        play(s, 0);
        checks++;
        if (got.size() - b != 1) begin
            errors++;
            $display("FAIL aapay_count frames=%0d exp=1", got.size() - b);
        end else begin
            checks++;
            if (got[b].t !== 8'h02 || got[b].l !== 8'h01 || got[b].p[7:0] !== 8'hAA) begin
                errors++;
                $display("FAIL aapay_fields got %h %h %h exp 02 01 AA", got[b].t, got[b].l, got[b].p[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bq_t s;
        int  b, c0, l0;
        s = {8'hAA, 8'h01, 8'h02, 8'h10};
        play(s, 0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got=%b exp=1", bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_type !== 8'h00 || bus.frame_len !== 8'h00 || bus.payload_bus !== '0) begin
            errors++;
            $display("FAIL midrst_clear busy=%b t=%h l=%h p=%h exp all 0", bus.busy, bus.frame_type, bus.frame_len, bus.payload_bus);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        foreach (mbuf[k]) mbuf[k] = 8'h00;
        b = got.size(); c0 = n_chk; l0 = n_len;
        s = {8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        play(s, 2);
        checks++;
        if (got.size() - b != 1 || n_chk != c0 || n_len != l0) begin
            errors++;
            $display("FAIL midrst_after frames=%0d chk=%0d len=%0d exp=1/0/0", got.size() - b, n_chk - c0, n_len - l0);
        end else begin
            checks++;
            if (got[b].p !== exp_q[0].p || got[b].t !== 8'h01) begin
                errors++;
                $display("FAIL midrst_fields got t=%h p=%h exp 01 p=%h", got[b].t, got[b].p, exp_q[0].p);
            end
        end
    endtask

    task automatic test_timeout;
        bq_t s;
        int  b, t0 = n_to;
        s = {8'hAA, 8'h01};
        play(s, 0);
`ifdef RX_TIMEOUT_EN
        repeat (TO + 5) drive(1'b0, 8'h00);
        checks++;
        if (n_to - t0 != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort pulses=%0d busy=%b exp=1/0", n_to - t0, bus.busy);
        end
        b = got.size();
        s = {8'hAA, 8'h01, 8'h01, 8'h55, 8'h57};
        play(s, 0);
`else
        repeat (200) drive(1'b0, 8'h00);
        checks++;
        if (n_to != t0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL notimeout_wait pulses=%0d busy=%b exp=0/1", n_to - t0, bus.busy);
        end
        b = got.size();
        s = {8'h01, 8'h55, 8'h57};
        play(s, 0);
        s = {8'hAA, 8'h01, 8'h01, 8'h55, 8'h57};
        model_stream(s);
`endif
        checks++;
        if (got.size() - b != 1) begin
            errors++;
            $display("FAIL timeout_next frames=%0d exp=1", got.size() - b);
        end else begin
            checks++;
            if (got[b].t !== 8'h01 || got[b].p[7:0] !== 8'h55) begin
                errors++;
                $display("FAIL timeout_next_fields got %h %h exp 01 55", got[b].t, got[b].p[7:0]);
            end
        end
    endtask

    task automatic test_random;
        bq_t        s;
        int         b = got.size(), c0 = n_chk, l0 = n_len, bad = 0;
        int         kind, l;
        logic [7:0] sum, t, d;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(9, 0);
            if (kind == 0) begin
                d = 8'($urandom);
                s.push_back(d == 8'hAA ? 8'h00 : d);
            end else if (kind == 1) begin
                s.push_back(8'hAA);
                s.push_back(8'($urandom));
                s.push_back(8'($urandom_range(255, MAX_LEN + 1)));
            end else begin
                t = 8'($urandom);
                l = $urandom_range(MAX_LEN, 0);
                sum = t + 8'(l);
                s.push_back(8'hAA);
                s.push_back(t);
                s.push_back(8'(l));
                for (int k = 0; k < l; k++) begin
                    d = 8'($urandom);
                    s.push_back(d);
                    sum = sum + d;
                end
                if (kind == 2) sum = sum + 8'($urandom_range(255, 1));
                s.push_back(sum);
            end
        end
        play(s, 2);
        checks++;
        if (got.size() - b != exp_q.size() || n_chk - c0 != exp_chk || n_len - l0 != exp_len) begin
            errors++;
            $display("FAIL rand_counts frames=%0d chk=%0d len=%0d exp=%0d/%0d/%0d",
                     got.size() - b, n_chk - c0, n_len - l0, exp_q.size(), exp_chk, exp_len);
        end else begin
            foreach (exp_q[i]) begin
                if (got[b+i] !== exp_q[i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_frames mismatched=%0d exp=0 of %0d", bad, exp_q.size());
            end
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (n_viol != 0) begin
            errors++;
            $display("FAIL pulse_protocol violations=%0d exp=0", n_viol);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        foreach (mbuf[k]) mbuf[k] = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_gaps();
        test_zero_len();
        test_aa_payload();
        test_reset_mid();
        test_timeout();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rx_frame.md
Name: rx_frame

Overview:
Receive-side frame parser for the UART link. It consumes a byte stream from the UART receiver and recognises frames of the form [0xAA][TYPE][LEN][PAYLOAD x LEN][CHK]. CHK is the 8-bit sum, mod 256, of TYPE, LEN and every payload byte; the SOF byte is excluded. Good frames are published to the command/RFID layer as a registered type, length and payload bus, plus a one-cycle valid pulse. Malformed frames are dropped and flagged.

Parameters:
MAX_LEN, 32, maximum accepted payload bytes (1..255); sizes the payload buffer and bus.
TIMEOUT_CYCLES, 100000, inter-byte idle limit in clk cycles; used only when RX_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle
frame_valid  output  1  one-cycle pulse; a good frame has been published
frame_type  output  8  TYPE of the last good frame
frame_len  output  8  LEN of the last good frame
payload_bus  output  8*MAX_LEN  payload of the last good frame; byte i at bits [8*i+7:8*i]
chk_err  output  1  one-cycle pulse on checksum mismatch
len_err  output  1  one-cycle pulse when LEN > MAX_LEN
timeout_err  output  1  one-cycle pulse on inter-byte timeout (tied 0 without RX_TIMEOUT_EN)
busy  output  1  high while a frame is partially received (state != R_SOF)

Behaviour:
- Reset is asynchronous, active-high, on clk/rst. Every output resets to 0, payload_bus included. State resets to R_SOF; the internal buffer, index and running sum reset to 0.
- States advance only in cycles where rx_valid=1. With rx_valid=0 the state holds.
- R_SOF:
  - byte == 0xAA: clear sum and idx, go to R_TYPE.
  - any other byte: discard and stay.
- R_TYPE: latch the byte into type_q; sum <= byte; go to R_LEN.
- R_LEN:
  - byte > MAX_LEN: pulse len_err next cycle, go to R_SOF.
  - byte == 0: latch len_q, sum += byte, go to R_CHK.
  - otherwise: latch len_q, sum += byte, go to R_PAY.
- R_PAY:
  - buf[idx] <= byte; sum += byte; idx += 1.
  - when idx+1 == len_q, go to R_CHK.
  - 0xAA is ordinary data here; there is no resynchronisation inside a frame.
- R_CHK:
  - byte == sum: frame_type <= type_q, frame_len <= len_q, copy buf into payload_bus; frame_valid pulses for 1 cycle.
  - byte != sum: chk_err pulses for 1 cycle; published outputs are unchanged.
  - Either way, go to R_SOF.
- Latency: frame_valid/chk_err/len_err go high in the cycle after the clock edge that samples the deciding byte, i.e. registered with 1-cycle latency.
- Published outputs hold until the next good frame. Bytes of payload_bus at index >= frame_len keep stale contents from earlier frames; consumers must honour frame_len.
- All arithmetic is 8-bit wrap-around; idx is 8 bits.
- The frame_valid and error pulses are mutually exclusive and never exceed 1 cycle.
- The UART delivers at most one byte per cycle. Back-to-back rx_valid on consecutive cycles must be accepted with no loss. A frame may start on the rx_valid immediately after the CHK byte.
- Reset mid-frame aborts the frame silently: no error pulse, outputs cleared.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: a counter clears on every rx_valid and increments each cycle while state != R_SOF. When it reaches TIMEOUT_CYCLES, the frame is aborted: go to R_SOF, pulse timeout_err for 1 cycle, published outputs unchanged. The counter is idle in R_SOF.
- Not defined: no counter exists and timeout_err is constant 0. A partial frame waits indefinitely.

Test Plan:
- AA 01 02 10 20 33 back-to-back -> one frame_valid; frame_type=01, frame_len=02, payload byte0=10, byte1=20; no errors.
- AA 01 02 10 20 34 -> chk_err pulse; frame_valid never asserted; outputs keep previous values.
- Garbage 00 FF then AA 07 01 55 5D, with gaps of 0-5 idle cycles between bytes -> frame_valid; type=07, len=01, byte0=55.
- AA 05 00 05 (zero length) -> frame_valid, len=00; then, with MAX_LEN=32, AA 01 21 -> len_err; a following AA 01 00 01 is accepted.
- Assert rst after AA 01 02 10 -> all outputs 0, busy=0, no error pulses; a full frame then parses correctly. Also AA 02 01 AA AD -> valid, byte0=AA.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=50: AA 01, then idle 50 cycles -> timeout_err pulse, busy=0; the next complete frame is accepted.
